fifo_rd_drain: RTL and testbench



---
 rtl/fifo_rd_drain_if.sv | 31 +++
 rtl/fifo_rd_drain.sv | 86 ++++++++
 tb/tb_fifo_rd_drain.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_drain_if.sv
// ---------------------------------------------------------------------------
// fifo_rd_drain_if : FIFO read port plus framed valid/ready stream.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fifo_rd_drain_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
);
  logic                 drain_en;
  logic                 empty;
  logic [WIDTH-1:0]     data_r;
  logic                 en_r;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_last;
  logic                 out_ready;
  logic [CNT_WIDTH-1:0] word_cnt;

  modport master (
    input  drain_en, empty, data_r, out_ready,
    output en_r, out_data, out_valid, out_last, word_cnt
  );

  modport slave (
    output drain_en, empty, data_r, out_ready,
    input  en_r, out_data, out_valid, out_last, word_cnt
  );
endinterface

`default_nettype wire

// File: rtl/fifo_rd_drain.sv
// ---------------------------------------------------------------------------
// fifo_rd_drain : drains the async FIFO read port into a framed stream.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_rd_drain #(
  parameter int WIDTH     = 8,
  parameter int PKT_LEN   = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic             clk_r,
  input  logic             rst_r,
  fifo_rd_drain_if.master  bus
);
  localparam int              BEAT_W      = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] c_last_beat = BEAT_W'(PKT_LEN - 1);

  logic [1:0]           r_occ;
  logic [1:0]           r_wptr;
  logic [1:0]           r_rptr;
  logic                 r_pend;
  logic [BEAT_W-1:0]    r_beat;
  logic [CNT_WIDTH-1:0] r_word_cnt;
  logic [2:0]           r_last;
  logic [WIDTH-1:0]     r_data [3];

  logic w_credit;
  logic w_en;
  logic w_capture;
  logic w_valid;
  logic w_xfer;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit counts the in-flight read so the buffer can never overflow.
  assign w_credit  = ({1'b0, r_occ} + {2'b00, r_pend}) < 3'd3;
  assign w_en      = bus.drain_en && !bus.empty && w_credit && !rst_r;
  assign w_capture = r_pend;
  assign w_valid   = (r_occ != 2'd0);
  assign w_xfer    = w_valid && bus.out_ready;

  always_ff @(posedge clk_r or posedge rst_r) begin
    if (rst_r) begin
      r_occ      <= 2'd0;
      r_wptr     <= 2'd0;
      r_rptr     <= 2'd0;
      r_pend     <= 1'b0;
      r_beat     <= '0;
      r_word_cnt <= '0;
      r_last     <= 3'b000;
    end else begin
      r_pend <= w_en;
      if (w_capture) begin
        r_last[r_wptr] <= (r_beat == c_last_beat);
        r_wptr         <= ptr_inc(r_wptr);
        r_beat         <= (r_beat == c_last_beat) ? '0 : r_beat + BEAT_W'(1);
      end
      if (w_xfer) begin
        r_rptr     <= ptr_inc(r_rptr);
        r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
      end
      case ({w_capture, w_xfer})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Payload needs no reset: it is masked whenever the buffer is empty.
  always_ff @(posedge clk_r) begin
    if (w_capture) begin
      r_data[r_wptr] <= bus.data_r;
    end
  end

  assign bus.en_r      = w_en;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_valid ? r_data[r_rptr] : '0;
  assign bus.out_last  = w_valid && r_last[r_rptr];
  assign bus.word_cnt  = r_word_cnt;
endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_drain.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_drain : FIFO model + queue-based reference for fifo_rd_drain.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fifo_rd_drain;
  localparam int WIDTH     = 8;
  localparam int PKT_LEN   = 16;
  localparam int CNT_WIDTH = 4;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             l;
  } ent_t;

  logic clk_r = 1'b0;
  logic rst_r = 1'b0;
  always #5 clk_r = ~clk_r;

  fifo_rd_drain_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  fifo_rd_drain #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk_r (clk_r),
    .rst_r (rst_r),
    .bus   (bus)
  );

  // fifo_q is the FIFO the DUT reads; ref_src/mq/m_* are the reference view.
  logic [WIDTH-1:0] fifo_q  [$];
  logic [WIDTH-1:0] ref_src [$];
  ent_t             mq      [$];
  bit               m_pend;
  logic [WIDTH-1:0] m_flight;
  int               m_seq;
  int               m_cnt;
  bit               gate;
  int               en_pulses;
  int               n_assert = 0;
  int               n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_empty();
    bus.empty = (fifo_q.size() == 0) || gate;
  endtask

  task automatic load(input logic [WIDTH-1:0] w);
    fifo_q.push_back(w);
    ref_src.push_back(w);
    drive_empty();
  endtask

  task automatic step();
    bit   exp_en;
    bit   xfer;
    bit   act_en;
    ent_t head;
    @(negedge clk_r);
    exp_en = bus.drain_en && !gate && (ref_src.size() != 0) && ((mq.size() + int'(m_pend)) < 3);
    check("en_r", 32'(bus.en_r), 32'(exp_en));
    check("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      head = mq[0];
      check("out_data", 32'(bus.out_data), 32'(head.d));
      check("out_last", 32'(bus.out_last), 32'(head.l));
    end else begin
      check("out_data_idle", 32'(bus.out_data), 32'h0);
      check("out_last_idle", 32'(bus.out_last), 32'h0);
    end
    check("word_cnt", 32'(bus.word_cnt), 32'(m_cnt % (1 << CNT_WIDTH)));
    xfer   = (mq.size() != 0) && bus.out_ready;
    act_en = bus.en_r;
    if (act_en) en_pulses++;
    @(posedge clk_r);
    if (xfer) begin
      head = mq.pop_front();
      m_cnt++;
    end
    if (m_pend) begin
      mq.push_back('{m_flight, ((m_seq % PKT_LEN) == PKT_LEN - 1)});
      m_seq++;
    end
    m_pend = exp_en;
    if (exp_en) m_flight = ref_src.pop_front();
    #1;
    if (act_en && fifo_q.size() != 0) bus.data_r = fifo_q.pop_front();
    else bus.data_r = '0;
    drive_empty();
  endtask

  task automatic async_reset();
    #2 rst_r = 1'b1;
    #1;
    check("rst_en_r", 32'(bus.en_r), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_data", 32'(bus.out_data), 32'h0);
    check("rst_out_last", 32'(bus.out_last), 32'h0);
    check("rst_word_cnt", 32'(bus.word_cnt), 32'h0);
    mq.delete();
    fifo_q.delete();
    ref_src.delete();
    m_pend     = 1'b0;
    m_seq      = 0;
    m_cnt      = 0;
    bus.data_r = '0;
    drive_empty();
    repeat (2) @(posedge clk_r);
    #1 rst_r = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.drain_en  = 1'b0;
    bus.out_ready = 1'b0;
    bus.data_r    = '0;
    gate          = 1'b0;
    m_pend        = 1'b0;
    m_flight      = '0;
    m_seq         = 0;
    m_cnt         = 0;
    en_pulses     = 0;
    drive_empty();

    // Reset values, then idle with the FIFO empty.
    async_reset();
    bus.drain_en = 1'b1;
    repeat (3) step();

    // Streaming 0x01..0x20 with downstream always ready.
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 32; i++) load(WIDTH'(i));
    repeat (40) step();
    check("stream_word_cnt", 32'(bus.word_cnt), 32'(32 % (1 << CNT_WIDTH)));

    // Backpressure: only three reads may be issued.
    bus.out_ready = 1'b0;
    en_pulses     = 0;
    for (int i = 0; i < 10; i++) load(WIDTH'(8'h40 + i));
    repeat (8) step();
    check("bp_en_pulses", 32'(en_pulses), 32'd3);
    bus.out_ready = 1'b1;
    repeat (14) step();

    // Drain enable drop and re-enable mid-packet.
    for (int i = 0; i < 20; i++) load(WIDTH'(8'h80 + i));
    repeat (3) step();
    bus.drain_en = 1'b0;
    en_pulses    = 0;
    repeat (6) step();
    check("drain_off_en_pulses", 32'(en_pulses), 32'd0);
    bus.drain_en = 1'b1;
    repeat (25) step();

    // Empty toggling every other cycle with random backpressure.
    for (int i = 0; i < 30; i++) load(WIDTH'($urandom_range(1, 255)));
    for (int i = 0; i < 80; i++) begin
      gate = ~gate;
      drive_empty();
      bus.out_ready = 1'($urandom_range(0, 1));
      step();
    end
    gate = 1'b0;
    drive_empty();
    bus.out_ready = 1'b1;
    repeat (40) step();
    check("interleave_drained", 32'(mq.size() + ref_src.size()), 32'd0);

    // Reset mid-packet, then 17 transfers to wrap the 4-bit counter.
    for (int i = 0; i < 10; i++) load(WIDTH'(8'hA0 + i));
    repeat (6) step();
    async_reset();
    bus.drain_en  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 17; i++) load(WIDTH'(8'hC0 + i));
    repeat (25) step();
    check("wrap_word_cnt", 32'(bus.word_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
